mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Iterative integer multiply/divide function unit (RV64 M extension, including the *W forms).
- Accepts one register-read request from the execute stage when idle and computes the result.
- Holds the result in an output register, marked valid by resp_opid[15], until the execute-stage result arbiter asserts the claim bit for this lane.
- Forms one lane of the fu_resp / fu_claim interface.

Parameters:
- prnum, 64, number of physical registers; PW = $clog2(prnum) is the width of prda.
- xlen, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  kill the in-flight op and drop any held response
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_opid  in  16  op id; bit 15 = valid tag
- req_funct  in  4  [2:0] = RISC-V funct3 (MUL..REMU); [3] = word op
- req_a  in  64  operand rs1 value
- req_b  in  64  operand rs2 value
- req_prda  in  PW  destination physical register
- resp_opid  out  16  op id of the held result; bit 15 = response valid
- resp_prda  out  PW  destination physical register of the held result
- resp_data  out  64  result value
- claim  in  1  arbiter has taken the response this cycle

Behaviour:
- Reset (async) sets state=IDLE, counter=0, resp_opid=0, resp_prda=0, resp_data=0, req_ready=0 while rst is high.
- States:
  - IDLE: req_ready=1. Transitions:
    - accept when req_valid & req_opid[15] & ~flush;
    - MUL/MULH/MULHSU/MULHU -> MUL;
    - DIV family with special case -> DONE;
    - other DIV family -> DIV.
  - MUL: the next edge writes the response and moves to DONE.
  - DIV: restoring division on magnitudes, one quotient bit per edge. counter loads N = 64, or 32 for word ops, and decrements each edge. The edge where counter = 1 applies sign fix-up, writes the response and moves to DONE.
  - DONE: holds the response. The edge with claim=1 clears resp_opid[15] and moves to IDLE. No new accept in this cycle (req_ready=0).
- Latency, counted as edges from the accept edge to the edge that writes the response:
  - MUL: 1 edge (response visible the cycle after the next edge).
  - DIV, 64-bit: 64 edges.
  - DIVW family: 32 edges.
  - Special cases: written at the accept edge itself (0 extra edges).
- Operand conditioning:
  - Word ops: use a[31:0] and b[31:0]; sign-extend for signed ops, zero-extend for unsigned ops.
  - Final result sign-extended from bit 31.
  - MULH and MULHSU are not word ops; the word bit is ignored for them.
- Multiply results:
  - MUL: low 64 bits of the product.
  - MULH: high 64 bits, signed×signed.
  - MULHSU: high 64 bits, signed×unsigned.
  - MULHU: high 64 bits, unsigned×unsigned.
- Divide special cases (width N):
  - b=0: quotient = all ones; remainder = a.
  - Signed overflow (a = -2^(N-1), b = -1): quotient = a; remainder = 0.
  - These results are sign-extended to 64 bits for word ops.
- Sign rules: quotient is negative iff the operand signs differ (signed ops only); remainder takes the sign of the dividend.
- Response side:
  - resp_opid/resp_prda are copied from the request at accept and are stable while DONE.
  - resp_data changes only on the writing edge.
  - claim while resp_opid[15]=0 is ignored.
- flush:
  - Next edge forces IDLE and clears resp_opid[15], in any state including DONE.
  - A simultaneous req_valid is not accepted.
  - A simultaneous claim is harmless.
- Reset mid-operation: divide is abandoned and the result is never presented.
- req_valid with req_opid[15]=0 is ignored.

Test Plan:
- Reset asserted mid-DIV (counter 30) -> resp_opid=0, req_ready=0 while rst high; IDLE and req_ready=1 after release.
- MUL a=7, b=-3, opid=0x8005, prda=9 -> one edge after accept: resp_opid=0x8005, resp_prda=9, resp_data=0xFFFF_FFFF_FFFF_FFEB; held 5 cycles without claim; cleared on claim edge; req_ready=1 next cycle.
- DIV a=-20, b=3 -> response written on the 64th edge after accept; data=0xFFFF_FFFF_FFFF_FFFA. REM same operands -> data=0xFFFF_FFFF_FFFF_FFFE (-2).
- DIVUW a=0x1_0000_0010, b=4 -> response on the 32nd edge; data=0x4.
- DIV by zero a=5 -> response visible the cycle after accept; data=0xFFFF_FFFF_FFFF_FFFF. REM same -> data=5. DIV 0x8000_0000_0000_0000 / -1 -> data=0x8000_0000_0000_0000.
- flush at DIV edge 10 -> resp_opid[15] never asserts; a new MULHU a=b=2^63 accepted after the flush -> data=0x4000_0000_0000_0000.

Source files
------------

// File: rtl/mdu_unit.sv
// mdu_unit: iterative RV64 M-extension multiply/divide lane (including *W forms), fu_resp/fu_claim style.
// Latency: MUL family 1 edge after accept, DIV 64 edges, DIVW 32 edges, divide special cases at the accept edge.
// Backpressure: req_ready only in IDLE; the result is held (resp_opid[15]=1) until claim; flush kills everything.
// Ports: clk/rst (async active-high), flush, req_* (valid/ready request), resp_* (held result), claim.
module mdu_unit #(
    parameter int prnum = 64,
    parameter int xlen  = 64,
    localparam int PW   = $clog2(prnum)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [15:0]     req_opid,
    input  logic [3:0]      req_funct,
    input  logic [xlen-1:0] req_a,
    input  logic [xlen-1:0] req_b,
    input  logic [PW-1:0]   req_prda,
    output logic [15:0]     resp_opid,
    output logic [PW-1:0]   resp_prda,
    output logic [xlen-1:0] resp_data,
    input  logic            claim
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    // Word results are always sign-extended from bit 31.
    function automatic logic [63:0] fn_fin(input logic word, input logic [63:0] x);
        return word ? {{32{x[31]}}, x[31:0]} : x;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_cnt;
    logic [15:0] r_resp_opid;
    logic [PW-1:0] r_resp_prda;
    logic [63:0] r_resp_data;

    // r_a/r_b: multiply operands in MUL, dividend shift register / divisor magnitude in DIV.
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [63:0] r_rem;
    logic        r_a_x;
    logic        r_b_x;
    logic [2:0]  r_f3;
    logic        r_word;
    logic        r_neg_q;
    logic        r_neg_r;

    // ---------------- request decode and operand conditioning ----------------
    logic [2:0]  w_f3;
    logic        w_is_mul;
    logic        w_word;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_div_signed;
    logic [63:0] w_a_c;
    logic [63:0] w_b_c;
    logic [63:0] w_a_mag;
    logic [63:0] w_b_mag;
    logic [63:0] w_quo_init;
    logic        w_b_zero;
    logic        w_ovf;
    logic        w_special;
    logic [63:0] w_spec_res;
    logic        w_accept;

    assign w_f3         = req_funct[2:0];
    assign w_is_mul     = ~w_f3[2];
    // MULH/MULHSU/MULHU have no word form; the word bit is ignored for them.
    assign w_word       = req_funct[3] & (w_f3 == 3'd0 || w_f3[2]);
    assign w_div_signed = ~w_f3[0];
    assign w_a_signed   = w_is_mul ? (w_f3 != 3'd3) : w_div_signed;
    assign w_b_signed   = w_is_mul ? (w_f3 <= 3'd1) : w_div_signed;

    assign w_a_c = !w_word ? req_a : {{32{w_a_signed & req_a[31]}}, req_a[31:0]};
    assign w_b_c = !w_word ? req_b : {{32{w_b_signed & req_b[31]}}, req_b[31:0]};

    assign w_a_mag = (w_div_signed && w_a_c[63]) ? -w_a_c : w_a_c;
    assign w_b_mag = (w_div_signed && w_b_c[63]) ? -w_b_c : w_b_c;
    // Word divides run 32 steps, so the dividend starts in the upper half.
    assign w_quo_init = w_word ? {w_a_mag[31:0], 32'd0} : w_a_mag;

    assign w_b_zero = (w_b_c == 64'd0);
    assign w_ovf    = w_div_signed && (w_b_c == 64'hFFFF_FFFF_FFFF_FFFF) &&
                      (w_a_c == (w_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    assign w_special = ~w_is_mul & (w_b_zero | w_ovf);

    // funct3[1] selects remainder within the divide family.
    always_comb begin
        w_spec_res = 64'd0;
        if (w_b_zero)
            w_spec_res = w_f3[1] ? w_a_c : 64'hFFFF_FFFF_FFFF_FFFF;
        else
            w_spec_res = w_f3[1] ? 64'd0 : w_a_c;
    end

    assign w_accept = req_valid & req_opid[15] & ~flush & (r_state == S_IDLE);

    // ---------------- multiply ----------------
    // Operands are sign/zero-extended to 128 bits; the low 128 bits of the
    // product are exact for any 65x65-bit signed product needed here.
    logic [127:0] w_ma;
    logic [127:0] w_mb;
    logic [127:0] w_prod;
    logic [63:0]  w_mul_res;

    assign w_ma      = {{64{r_a_x}}, r_a};
    assign w_mb      = {{64{r_b_x}}, r_b};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = fn_fin(r_word, (r_f3 == 3'd0) ? w_prod[63:0] : w_prod[127:64]);

    // ---------------- restoring divide step ----------------
    logic [64:0] w_shift;
    logic [65:0] w_trial;
    logic        w_ge;
    logic [63:0] w_rem_nxt;
    logic [63:0] w_quo_nxt;
    logic [63:0] w_q_fix;
    logic [63:0] w_r_fix;
    logic [63:0] w_div_res;

    assign w_shift   = {r_rem, r_a[63]};
    assign w_trial   = {1'b0, w_shift} - {2'b00, r_b};
    assign w_ge      = ~w_trial[65];
    assign w_rem_nxt = w_ge ? w_trial[63:0] : w_shift[63:0];
    assign w_quo_nxt = {r_a[62:0], w_ge};
    assign w_q_fix   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fix   = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    assign w_div_res = fn_fin(r_word, r_f3[1] ? w_r_fix : w_q_fix);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept)
                            w_state_nxt = w_is_mul ? S_MUL : (w_special ? S_DONE : S_DIV);
                S_MUL:  w_state_nxt = S_DONE;
                S_DIV:  if (r_cnt == 7'd1) w_state_nxt = S_DONE;
                S_DONE: if (claim) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = (r_state == S_IDLE) & ~rst;
    end

    assign resp_opid = r_resp_opid;
    assign resp_prda = r_resp_prda;
    assign resp_data = r_resp_data;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 7'd0;
            r_resp_opid <= 16'd0;
            r_resp_prda <= '0;
            r_resp_data <= 64'd0;
            r_a         <= 64'd0;
            r_b         <= 64'd0;
            r_rem       <= 64'd0;
            r_a_x       <= 1'b0;
            r_b_x       <= 1'b0;
            r_f3        <= 3'd0;
            r_word      <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else if (flush) begin
            r_cnt          <= 7'd0;
            r_resp_opid[15] <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    // The id is captured now; bit 15 rises only when data is written.
                    r_resp_opid <= {w_special, req_opid[14:0]};
                    r_resp_prda <= req_prda;
                    r_f3        <= w_f3;
                    r_word      <= w_word;
                    r_a         <= w_is_mul ? w_a_c : w_quo_init;
                    r_b         <= w_is_mul ? w_b_c : w_b_mag;
                    r_a_x       <= w_a_signed & w_a_c[63];
                    r_b_x       <= w_b_signed & w_b_c[63];
                    r_rem       <= 64'd0;
                    r_neg_q     <= w_div_signed & (w_a_c[63] ^ w_b_c[63]);
                    r_neg_r     <= w_div_signed & w_a_c[63];
                    r_cnt       <= (w_is_mul || w_special) ? 7'd0 : (w_word ? 7'd32 : 7'd64);
                    if (w_special) r_resp_data <= fn_fin(w_word, w_spec_res);
                end
                S_MUL: begin
                    r_resp_data     <= w_mul_res;
                    r_resp_opid[15] <= 1'b1;
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_a   <= w_quo_nxt;
                    r_cnt <= r_cnt - 7'd1;
                    if (r_cnt == 7'd1) begin
                        r_resp_data     <= w_div_res;
                        r_resp_opid[15] <= 1'b1;
                    end
                end
                S_DONE: if (claim) r_resp_opid[15] <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
